// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranging controller: trigger on each rate_in rise, time the echo width in clk_in cycles.
// Optional ULTRA_AVG_EN: report the running mean of the last four successful widths instead of the raw width.
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rate_in,
  input  logic             echo_in,
  output logic             trig_out,
  output logic [CNT_W-1:0] echo_cycles_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             busy_out
);
  localparam int unsigned TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_e;

  state_e            state_q, state_d;
  logic              echo_s1_q, echo_s_q, echo_prev_q;
  logic              rate_q, rate_prev_q;
  logic              trig_q;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  echo_cycles_q, echo_cycles_d;
  logic [CNT_W-1:0]  result;
  logic              rate_rise, echo_rise, timed_out, done_load;

  assign rate_rise = rate_q & ~rate_prev_q;
  assign echo_rise = echo_s_q & ~echo_prev_q;

`ifdef ULTRA_AVG_EN
  // Three stored widths plus the one just measured form the four-entry window.
  logic [CNT_W-1:0] hist_q [3];
  logic [CNT_W+1:0] avg_sum;

  assign avg_sum = (CNT_W+2)'(width_q) + (CNT_W+2)'(hist_q[0])
                 + (CNT_W+2)'(hist_q[1]) + (CNT_W+2)'(hist_q[2]);
  assign result  = avg_sum[CNT_W+1:2];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) hist_q[i] <= '0;
    end else if (done_load) begin
      hist_q[0] <= width_q;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  assign result = width_q;
`endif

  always_comb begin
    state_d       = state_q;
    trig_cnt_d    = trig_cnt_q;
    to_cnt_d      = to_cnt_q;
    width_d       = width_q;
    echo_cycles_d = echo_cycles_q;
    timed_out     = 1'b0;
    done_load     = 1'b0;
    case (state_q)
      IDLE: if (rate_rise) begin
        state_d    = TRIG;
        trig_cnt_d = '0;
      end
      TRIG: if (trig_cnt_q == TRIG_LAST) begin
        state_d  = WAIT_RISE;
        to_cnt_d = '0;
      end else begin
        trig_cnt_d = trig_cnt_q + 1'b1;
      end
      WAIT_RISE: if (to_cnt_q == TO_LIMIT) begin
        timed_out = 1'b1;
        state_d   = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (echo_rise) begin
          state_d = MEASURE;
          width_d = CNT_W'(1);
        end
      end
      // Timeout is tested first so it wins over a coincident echo fall.
      MEASURE: if (to_cnt_q == TO_LIMIT) begin
        timed_out = 1'b1;
        state_d   = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!echo_s_q) begin
          state_d       = DONE;
          done_load     = 1'b1;
          echo_cycles_d = result;
        end else if (width_q != '1) begin
          width_d = width_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      echo_s1_q     <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_prev_q   <= 1'b0;
      rate_q        <= 1'b0;
      rate_prev_q   <= 1'b0;
      trig_q        <= 1'b0;
      trig_cnt_q    <= '0;
      to_cnt_q      <= '0;
      width_q       <= '0;
      echo_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      echo_s1_q     <= echo_in;
      echo_s_q      <= echo_s1_q;
      echo_prev_q   <= echo_s_q;
      rate_q        <= rate_in;
      rate_prev_q   <= rate_q;
      trig_q        <= (state_d == TRIG);
      trig_cnt_q    <= trig_cnt_d;
      to_cnt_q      <= to_cnt_d;
      width_q       <= width_d;
      echo_cycles_q <= echo_cycles_d;
    end
  end

  assign trig_out        = trig_q;
  assign echo_cycles_out = echo_cycles_q;
  assign valid_out       = (state_q == DONE);
  assign timeout_out     = timed_out;
  assign busy_out        = (state_q != IDLE);
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: per-cycle expectation timeline built from measurement rules, plus literal checks.
module tb_ultrasonic_ranger;
  localparam int TRIG = 10;
  localparam int TO   = 200;
  localparam int CW   = 32;
  localparam int NC   = 8192;
`ifdef ULTRA_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, rate_in, echo_in;
  logic          trig_out, valid_out, timeout_out, busy_out;
  logic [CW-1:0] echo_cycles_out;

  ultrasonic_ranger #(.TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rate_in(rate_in), .echo_in(echo_in),
    .trig_out(trig_out), .echo_cycles_out(echo_cycles_out), .valid_out(valid_out),
    .timeout_out(timeout_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Expected output timeline, indexed by cycle number.
  bit            exp_trig [NC];
  bit            exp_busy [NC];
  bit            exp_valid[NC];
  bit            exp_to   [NC];
  logic [CW-1:0] exp_val  [NC];
  int unsigned   hist[$];

  int  n_checks = 0, n_err = 0;
  bit  chk_en = 1'b0;
  int  trig_hi, n_valid, n_to, last_valid_c, last_to_c, fall_c;

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en && cyc < NC) begin
      check("trig_out",        {31'd0, trig_out},    {31'd0, exp_trig[cyc]});
      check("busy_out",        {31'd0, busy_out},    {31'd0, exp_busy[cyc]});
      check("valid_out",       {31'd0, valid_out},   {31'd0, exp_valid[cyc]});
      check("timeout_out",     {31'd0, timeout_out}, {31'd0, exp_to[cyc]});
      check("echo_cycles_out", echo_cycles_out,      exp_val[cyc]);
    end
    if (trig_out) trig_hi++;
    if (valid_out) begin n_valid++; last_valid_c = cyc; end
    if (timeout_out) begin n_to++; last_to_c = cyc; end
  end

  function automatic logic [CW-1:0] model_result(input int unsigned n);
    longint unsigned s = 0;
    if (!AVG) return n;
    hist.push_front(n);
    if (hist.size() > 4) void'(hist.pop_back());
    foreach (hist[i]) s += hist[i];
    return CW'(s >> 2);
  endfunction

  task automatic set_val_from(input int c, input logic [CW-1:0] v);
    for (int i = c; i < NC; i++) exp_val[i] = v;
  endtask

  task automatic set_busy(input int c0, input int c1);
    for (int i = c0; i <= c1; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic expect_timeout(input int a);
    int w = a + 2 + TRIG;
    set_busy(a + 2, w + TO);
    exp_to[w + TO] = 1'b1;
  endtask

  // Echo held high in cycles e..e+n-1; the synchronized edges land two cycles later.
  task automatic expect_echo(input int a, input int e, input int n);
    int w = a + 2 + TRIG;
    int v = e + n + 3;
    if (e + 2 >= w && e + n + 2 - w < TO) begin
      set_busy(a + 2, v);
      exp_valid[v] = 1'b1;
      set_val_from(v, model_result(n));
    end else begin
      expect_timeout(a);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clr_cnt();
    trig_hi = 0; n_valid = 0; n_to = 0;
  endtask

  // rate_in rises in the current cycle; trigger occupies the cycles a+2 .. a+1+TRIG.
  task automatic start_meas(output int a, output int w);
    a = cyc;
    w = a + 2 + TRIG;
    rate_in = 1'b1;
    for (int i = a + 2; i < w; i++) exp_trig[i] = 1'b1;
  endtask

  task automatic run_echo(input int dly, input int n, input bit dup);
    int a, w, e;
    clr_cnt();
    start_meas(a, w);
    e = w + dly;
    expect_echo(a, e, n);
    wait_until(a + 5); rate_in = 1'b0;
    wait_until(e); echo_in = 1'b1;
    if (dup) begin
      wait_until(e + 5); rate_in = 1'b1;
      wait_until(e + 8); rate_in = 1'b0;
    end
    wait_until(e + n); echo_in = 1'b0;
    fall_c = e + n;
    wait_until(e + n + 8);
  endtask

  task automatic run_noecho();
    int a, w;
    clr_cnt();
    start_meas(a, w);
    expect_timeout(a);
    wait_until(a + 5); rate_in = 1'b0;
    wait_until(w + TO + 5);
    check("to_count",   n_to, 1);
    check("to_latency", last_to_c - w, 200);
    check("to_novalid", n_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, w, e, r;
    rst_in = 1'b1; rate_in = 1'b0; echo_in = 1'b0;
    for (int i = 0; i < NC; i++) exp_val[i] = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_trig",  {31'd0, trig_out},    0);
    check("rst_busy",  {31'd0, busy_out},    0);
    check("rst_valid", {31'd0, valid_out},   0);
    check("rst_to",    {31'd0, timeout_out}, 0);
    check("rst_val",   echo_cycles_out,      0);
    rst_in = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();

    // Basic 50-cycle echo, 20 cycles after the trigger falls.
    run_echo(20, 50, 1'b0);
    check("s1_val",     echo_cycles_out, AVG ? 12 : 50);
    check("s1_trig_len", trig_hi, 10);
    check("s1_nvalid",  n_valid, 1);
    check("s1_nto",     n_to, 0);
    check("s1_latency", last_valid_c - fall_c, 3);

    // No echo at all.
    run_noecho();
    check("s2_hold", echo_cycles_out, AVG ? 12 : 50);
    check("s2_idle", {31'd0, busy_out}, 0);

    // Echo already high before the trigger is not a rise.
    echo_in = 1'b1;
    repeat (5) tick();
    run_noecho();
    echo_in = 1'b0;
    repeat (5) tick();
    run_echo(15, 30, 1'b0);
    check("s3_val", echo_cycles_out, AVG ? 20 : 30);

    // Second rate rise during MEASURE is dropped.
    run_echo(10, 40, 1'b1);
    check("s4_trig_len", trig_hi, 10);
    check("s4_nvalid",   n_valid, 1);
    check("s4_val",      echo_cycles_out, AVG ? 30 : 40);
    run_echo(10, 25, 1'b0);
    check("s4_next_trig", trig_hi, 10);
    check("s4_next_val",  echo_cycles_out, AVG ? 36 : 25);

    // Reset in the middle of a 40-cycle echo.
    clr_cnt();
    start_meas(a, w);
    e = w + 10;
    r = e + 15;
    set_busy(a + 2, r);
    set_val_from(r + 1, '0);
    hist.delete();
    wait_until(a + 5); rate_in = 1'b0;
    wait_until(e); echo_in = 1'b1;
    wait_until(r); rst_in = 1'b1;
    wait_until(r + 1); rst_in = 1'b0;
    check("s5_busy", {31'd0, busy_out}, 0);
    check("s5_val",  echo_cycles_out, 0);
    wait_until(e + 40); echo_in = 1'b0;
    wait_until(e + 48);
    check("s5_nvalid", n_valid, 0);
    check("s5_nto",    n_to, 0);

    // Averaging sequence; 192 is used as the last width because a 200-cycle
    // echo cannot fall before a 200-cycle timeout window closes.
    run_echo(5, 40, 1'b0);  check("s6_w40",  echo_cycles_out, AVG ? 10 : 40);
    run_echo(5, 80, 1'b0);  check("s6_w80",  echo_cycles_out, AVG ? 30 : 80);
    run_echo(5, 120, 1'b0); check("s6_w120", echo_cycles_out, AVG ? 60 : 120);
    run_echo(5, 160, 1'b0); check("s6_w160", echo_cycles_out, AVG ? 100 : 160);
    run_noecho();
    check("s6_hold", echo_cycles_out, AVG ? 100 : 160);
    run_echo(0, 192, 1'b0); check("s6_w192", echo_cycles_out, AVG ? 138 : 192);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
